// File: rtl/easyaxi_traffic_ctrl.sv
// Traffic sequencer for the EasyAXI top level.
// Runs NUM_ITER read-then-write session pairs, holding each enable for
// HOLD_CYC cycles after its done and idling GAP_CYC cycles between sessions.
// A watchdog aborts the run into ERR if a request is never answered.
module easyaxi_traffic_ctrl #(
  parameter int NUM_ITER = 4,
  parameter int HOLD_CYC = 3,
  parameter int GAP_CYC  = 5,
  parameter int TIMEOUT  = 1024,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             rd_en,
  input  logic             rd_done,
  output logic             wr_en,
  input  logic             wr_done,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);

  // Counter widths; every counter is at least one bit wide.
  localparam int IT_W  = (NUM_ITER < 2) ? 1 : $clog2(NUM_ITER + 1);
  localparam int TM_MX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int TM_W  = (TM_MX < 2) ? 1 : $clog2(TM_MX);
  localparam int WD_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  // Terminal values: hold/gap/watchdog count 0..N-1, iteration counts sessions done.
  localparam logic [TM_W-1:0] HOLD_LAST = TM_W'(HOLD_CYC - 1);
  localparam logic [TM_W-1:0] GAP_LAST  = TM_W'(GAP_CYC - 1);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [IT_W-1:0] IT_LAST   = IT_W'(NUM_ITER - 1);

  typedef enum logic [3:0] {
    IDLE, RD_REQ, RD_HOLD, RD_GAP, WR_REQ, WR_HOLD, WR_GAP, DONE, ERR
  } state_t;

  state_t           state_q, state_d;
  logic [IT_W-1:0]  iter_q, iter_d;
  logic [TM_W-1:0]  tmr_q, tmr_d;     // shared hold/gap timer
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             rd_en_q, rd_en_d;
  logic             wr_en_q, wr_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // State register and all counters/outputs, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      iter_q   <= '0;
      tmr_q    <= '0;
      wdog_q   <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      iter_q   <= iter_d;
      tmr_q    <= tmr_d;
      wdog_q   <= wdog_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      rd_en_q  <= rd_en_d;
      wr_en_q  <= wr_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state and counter updates; outputs are decoded from the next state
  // so every output comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    tmr_d    = tmr_q;
    wdog_d   = wdog_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          iter_d   = '0;
          tmr_d    = '0;
          wdog_d   = '0;
          state_d  = (NUM_ITER == 0) ? DONE : RD_REQ;
        end
      end
      // A done on the last watchdog cycle still counts as completion.
      RD_REQ: begin
        if (rd_done) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          wdog_d   = '0;
          state_d  = RD_HOLD;
        end else if (wdog_q == WD_LAST) begin
          wdog_d  = '0;
          state_d = ERR;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      RD_HOLD: begin
        if (tmr_q == HOLD_LAST) begin
          tmr_d   = '0;
          state_d = RD_GAP;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      RD_GAP: begin
        if (tmr_q == GAP_LAST) begin
          tmr_d   = '0;
          state_d = WR_REQ;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      WR_REQ: begin
        if (wr_done) begin
          wr_cnt_d = wr_cnt_q + 1'b1;
          wdog_d   = '0;
          state_d  = WR_HOLD;
        end else if (wdog_q == WD_LAST) begin
          wdog_d  = '0;
          state_d = ERR;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      WR_HOLD: begin
        if (tmr_q == HOLD_LAST) begin
          tmr_d   = '0;
          state_d = WR_GAP;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      WR_GAP: begin
        if (tmr_q == GAP_LAST) begin
          tmr_d   = '0;
          iter_d  = iter_q + 1'b1;
          state_d = (iter_q == IT_LAST) ? DONE : RD_REQ;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    rd_en_d = (state_d == RD_REQ) || (state_d == RD_HOLD);
    wr_en_d = (state_d == WR_REQ) || (state_d == WR_HOLD);
    busy_d  = !((state_d == IDLE) || (state_d == DONE) || (state_d == ERR));
    done_d  = (state_d == DONE);
    err_d   = (state_d == ERR);
  end

  assign rd_en       = rd_en_q;
  assign wr_en       = wr_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = err_q;
  assign rd_cnt      = rd_cnt_q;
  assign wr_cnt      = wr_cnt_q;

endmodule

// File: tb/tb_easyaxi_traffic_ctrl.sv
// Self-checking bench for easyaxi_traffic_ctrl. Expected waveforms come from a
// session-timeline model: each session is "enable rises, done after L cycles,
// enable held HOLD more cycles, GAP idle cycles", laid out on a cycle axis.
module tb_easyaxi_traffic_ctrl;
  localparam int N    = 2;
  localparam int H    = 3;
  localparam int G    = 5;
  localparam int TO   = 16;
  localparam int CW   = 8;
  localparam int NS   = 2 * N;
  localparam int MAXC = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, start_z = 1'b0;
  logic rd_done = 1'b0, wr_done = 1'b0;
  logic rd_en, wr_en, busy, done, terr;
  logic [CW-1:0] rd_cnt, wr_cnt;
  logic rd_en_z, wr_en_z, busy_z, done_z, terr_z;
  logic [CW-1:0] rd_cnt_z, wr_cnt_z;

  int total = 0;
  int bad   = 0;
  int run_id = 0;

  int lat[NS];
  bit in_rd[MAXC], in_wr[MAXC];
  bit ex_rd[MAXC], ex_wr[MAXC], ex_busy[MAXC], ex_done[MAXC], ex_err[MAXC];
  bit acc_rd[MAXC], acc_wr[MAXC];
  bit obs_rd[MAXC], obs_wr[MAXC];
  logic [CW-1:0] ex_rc[MAXC], ex_wc[MAXC];
  int len, wr_hold_k;

  easyaxi_traffic_ctrl #(.NUM_ITER(N), .HOLD_CYC(H), .GAP_CYC(G), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rd_en(rd_en), .rd_done(rd_done), .wr_en(wr_en), .wr_done(wr_done),
    .busy(busy), .done(done), .timeout_err(terr), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  easyaxi_traffic_ctrl #(.NUM_ITER(0), .HOLD_CYC(H), .GAP_CYC(G), .TIMEOUT(TO), .CNT_W(CW)) dut_z (
    .clk(clk), .rst(rst), .start(start_z),
    .rd_en(rd_en_z), .rd_done(rd_done), .wr_en(wr_en_z), .wr_done(wr_done),
    .busy(busy_z), .done(done_z), .timeout_err(terr_z), .rd_cnt(rd_cnt_z), .wr_cnt(wr_cnt_z)
  );

  always #5 clk = ~clk;

  // Lay out the expected timeline from the latency list; cycle 1 is the first
  // cycle after the start pulse. Done inputs are random noise except inside
  // each own request window, where they are 0 until the answering pulse.
  task automatic build_model();
    int pos;
    int l;
    bit isrd;
    bit err;
    logic [CW-1:0] rc, wc;
    pos = 1; err = 1'b0; wr_hold_k = 0;
    for (int k = 0; k < MAXC; k++) begin
      in_rd[k] = 1'($urandom_range(0, 1));
      in_wr[k] = 1'($urandom_range(0, 1));
      ex_rd[k] = 0; ex_wr[k] = 0; acc_rd[k] = 0; acc_wr[k] = 0;
    end
    in_rd[0] = 0; in_wr[0] = 0;
    for (int s = 0; s < NS && !err; s++) begin
      isrd = (s % 2 == 0);
      l = lat[s];
      for (int k = pos; k < pos + ((l >= TO) ? TO : l); k++) begin
        if (isrd) in_rd[k] = 0; else in_wr[k] = 0;
      end
      if (l >= TO) begin
        for (int k = pos; k < pos + TO; k++) begin
          if (isrd) ex_rd[k] = 1; else ex_wr[k] = 1;
        end
        pos = pos + TO;
        err = 1'b1;
      end else begin
        if (isrd) begin
          in_rd[pos + l] = 1; acc_rd[pos + l] = 1;
        end else begin
          in_wr[pos + l] = 1; acc_wr[pos + l] = 1;
          if (wr_hold_k == 0) wr_hold_k = pos + l + 1;
        end
        for (int k = pos; k <= pos + l + H; k++) begin
          if (isrd) ex_rd[k] = 1; else ex_wr[k] = 1;
        end
        pos = pos + l + H + G + 1;
      end
    end
    len = pos + 3;
    rc = '0; wc = '0;
    for (int k = 1; k <= len; k++) begin
      ex_rc[k]   = rc;
      ex_wc[k]   = wc;
      rc         = rc + CW'(acc_rd[k]);
      wc         = wc + CW'(acc_wr[k]);
      ex_busy[k] = (k < pos);
      ex_done[k] = (k >= pos) && !err;
      ex_err[k]  = (k >= pos) && err;
    end
  endtask

  // Pulse start, then for each cycle compare every output with the timeline
  // and drive that cycle's done inputs. Optionally sprinkles start pulses
  // into busy cycles, where they must be ignored.
  task automatic execute(input int stop_k, input bit noise_start);
    int last;
    last = (stop_k < len) ? stop_k : len;
    run_id++;
    start = 1'b1; rd_done = 1'b0; wr_done = 1'b0;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      obs_rd[k] = rd_en; obs_wr[k] = wr_en;
      total += 7;
      if (rd_en !== ex_rd[k]) begin bad++; $display("FAIL run%0d cyc%0d rd_en got %b want %b", run_id, k, rd_en, ex_rd[k]); end
      if (wr_en !== ex_wr[k]) begin bad++; $display("FAIL run%0d cyc%0d wr_en got %b want %b", run_id, k, wr_en, ex_wr[k]); end
      if (busy !== ex_busy[k]) begin bad++; $display("FAIL run%0d cyc%0d busy got %b want %b", run_id, k, busy, ex_busy[k]); end
      if (done !== ex_done[k]) begin bad++; $display("FAIL run%0d cyc%0d done got %b want %b", run_id, k, done, ex_done[k]); end
      if (terr !== ex_err[k]) begin bad++; $display("FAIL run%0d cyc%0d timeout_err got %b want %b", run_id, k, terr, ex_err[k]); end
      if (rd_cnt !== ex_rc[k]) begin bad++; $display("FAIL run%0d cyc%0d rd_cnt got %0d want %0d", run_id, k, rd_cnt, ex_rc[k]); end
      if (wr_cnt !== ex_wc[k]) begin bad++; $display("FAIL run%0d cyc%0d wr_cnt got %0d want %0d", run_id, k, wr_cnt, ex_wc[k]); end
      rd_done = in_rd[k];
      wr_done = in_wr[k];
      start = noise_start && ex_busy[k] && ($urandom_range(0, 7) == 0);
    end
    start = 1'b0;
    if (last == len) begin
      rd_done = 1'b0; wr_done = 1'b0;
    end
    $display("run %0d: lat=%0d,%0d,%0d,%0d cycles=%0d rd_cnt=%0d wr_cnt=%0d done=%b err=%b",
             run_id, lat[0], lat[1], lat[2], lat[3], last, rd_cnt, wr_cnt, done, terr);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total += 9;
    if (rd_en !== 1'b0) begin bad++; $display("FAIL reset rd_en got %b want 0", rd_en); end
    if (wr_en !== 1'b0) begin bad++; $display("FAIL reset wr_en got %b want 0", wr_en); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got %b want 0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL reset done got %b want 0", done); end
    if (terr !== 1'b0) begin bad++; $display("FAIL reset timeout_err got %b want 0", terr); end
    if (rd_cnt !== 8'd0) begin bad++; $display("FAIL reset rd_cnt got %0d want 0", rd_cnt); end
    if (wr_cnt !== 8'd0) begin bad++; $display("FAIL reset wr_cnt got %0d want 0", wr_cnt); end
    if (done_z !== 1'b0) begin bad++; $display("FAIL reset zero-iter done got %b want 0", done_z); end
    if (busy_z !== 1'b0) begin bad++; $display("FAIL reset zero-iter busy got %b want 0", busy_z); end
    rst = 1'b0;
    // Without start, everything stays idle.
    repeat (4) begin
      @(posedge clk); #1;
      total++;
      if ({rd_en, wr_en, busy} !== 3'b000) begin bad++; $display("FAIL idle en/busy got %b want 000", {rd_en, wr_en, busy}); end
    end
  endtask

  task automatic test_basic();
    int nrd, nwr;
    for (int s = 0; s < NS; s++) lat[s] = 4;
    build_model();
    execute(MAXC, 1'b0);
    nrd = 0; nwr = 0;
    for (int k = 1; k <= len; k++) begin nrd += int'(obs_rd[k]); nwr += int'(obs_wr[k]); end
    total += 4;
    if (nrd != 16) begin bad++; $display("FAIL basic rd_en high cycles got %0d want 16", nrd); end
    if (nwr != 16) begin bad++; $display("FAIL basic wr_en high cycles got %0d want 16", nwr); end
    if (rd_cnt !== 8'd2 || wr_cnt !== 8'd2) begin bad++; $display("FAIL basic counts got %0d/%0d want 2/2", rd_cnt, wr_cnt); end
    if ({done, busy} !== 2'b10) begin bad++; $display("FAIL basic done/busy got %b want 10", {done, busy}); end
  endtask

  task automatic test_hold_timing();
    lat[0] = 9; lat[1] = 2; lat[2] = 1; lat[3] = 0;
    build_model();
    execute(MAXC, 1'b0);
    total += 4;
    if (obs_rd[13] !== 1'b1) begin bad++; $display("FAIL hold rd_en@13 got %b want 1", obs_rd[13]); end
    if (obs_rd[14] !== 1'b0) begin bad++; $display("FAIL hold rd_en@14 got %b want 0", obs_rd[14]); end
    if (obs_wr[18] !== 1'b0) begin bad++; $display("FAIL hold wr_en@18 got %b want 0", obs_wr[18]); end
    if (obs_wr[19] !== 1'b1) begin bad++; $display("FAIL hold wr_en@19 got %b want 1", obs_wr[19]); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < NS; s++) lat[s] = $urandom_range(0, 7);
      build_model();
      execute(MAXC, 1'b1);
    end
  endtask

  task automatic test_boundary();
    lat[0] = TO - 1; lat[1] = 0; lat[2] = 0; lat[3] = TO - 1;
    build_model();
    execute(MAXC, 1'b1);
    total++;
    if (rd_cnt !== 8'd2 || wr_cnt !== 8'd2 || done !== 1'b1) begin
      bad++; $display("FAIL boundary counts/done got %0d/%0d/%b want 2/2/1", rd_cnt, wr_cnt, done);
    end
  endtask

  task automatic test_timeout();
    lat[0] = TO; lat[1] = 0; lat[2] = 0; lat[3] = 0;
    build_model();
    execute(MAXC, 1'b0);
    total += 2;
    if ({terr, rd_en, busy} !== 3'b100) begin bad++; $display("FAIL timeout err/rd_en/busy got %b want 100", {terr, rd_en, busy}); end
    if (rd_cnt !== 8'd0) begin bad++; $display("FAIL timeout rd_cnt got %0d want 0", rd_cnt); end
    // Restart from ERR, this time expiring on a randomly chosen session.
    for (int s = 0; s < NS; s++) lat[s] = $urandom_range(0, 6);
    lat[$urandom_range(1, NS - 1)] = TO;
    build_model();
    execute(MAXC, 1'b1);
    // And recover from ERR with a clean run.
    for (int s = 0; s < NS; s++) lat[s] = $urandom_range(0, 6);
    build_model();
    execute(MAXC, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int s = 0; s < NS; s++) lat[s] = $urandom_range(0, 5);
    build_model();
    execute(wr_hold_k, 1'b0);
    total++;
    if (wr_en !== 1'b1) begin bad++; $display("FAIL midreset pre wr_en got %b want 1", wr_en); end
    #2 rst = 1'b1;
    #1;
    total += 3;
    if ({rd_en, wr_en, busy} !== 3'b000) begin bad++; $display("FAIL midreset en/busy got %b want 000", {rd_en, wr_en, busy}); end
    if (rd_cnt !== 8'd0 || wr_cnt !== 8'd0) begin bad++; $display("FAIL midreset counts got %0d/%0d want 0/0", rd_cnt, wr_cnt); end
    if ({done, terr} !== 2'b00) begin bad++; $display("FAIL midreset done/err got %b want 00", {done, terr}); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      rd_done = 1'($urandom_range(0, 1));
      wr_done = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      total++;
      if ({rd_en, wr_en, busy, rd_cnt, wr_cnt} !== 19'd0) begin
        bad++; $display("FAIL post-reset idle got en=%b%b busy=%b cnt=%0d/%0d want all 0", rd_en, wr_en, busy, rd_cnt, wr_cnt);
      end
    end
    rd_done = 1'b0; wr_done = 1'b0;
  endtask

  task automatic test_zero_iter();
    start_z = 1'b1;
    @(posedge clk); #1;
    start_z = 1'b0;
    total += 2;
    if (done_z !== 1'b1) begin bad++; $display("FAIL zero-iter done got %b want 1", done_z); end
    if (busy_z !== 1'b0) begin bad++; $display("FAIL zero-iter busy got %b want 0", busy_z); end
    for (int k = 0; k < 6; k++) begin
      rd_done = 1'($urandom_range(0, 1));
      wr_done = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      total++;
      if ({rd_en_z, wr_en_z, done_z, rd_cnt_z, wr_cnt_z} !== {2'b00, 1'b1, 16'd0}) begin
        bad++; $display("FAIL zero-iter hold got en=%b%b done=%b cnt=%0d/%0d want en=00 done=1 cnt=0/0",
                        rd_en_z, wr_en_z, done_z, rd_cnt_z, wr_cnt_z);
      end
    end
    rd_done = 1'b0; wr_done = 1'b0;
    $display("zero-iter run: done=%b busy=%b", done_z, busy_z);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_timing();
    test_random();
    test_boundary();
    test_timeout();
    test_reset_mid();
    test_zero_iter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
